// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard control: branch-operand forwarding, load/branch interlocks and EX divider stall FSM.
// Optional macro ID_MEM_FWD_EN enables MEM->ID branch-operand forwarding; otherwise such cases stall.
module id_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] id_rs_regf,
    input  logic [4:0] id_rt_regf,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic       ex_wr_en,
    input  logic       ex_is_load,
    input  logic [4:0] ex_wr_regf,
    input  logic       mem_wr_en,
    input  logic       mem_is_load,
    input  logic [4:0] mem_wr_regf,
    input  logic       ex_div_start,
    input  logic       exc_flush,
    output logic       forward_rs,
    output logic       forward_rt,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       flush_ex,
    output logic       div_busy,
    output logic       div_done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 2);

    div_state_e state_q;
    logic [5:0] cnt_q;

    logic live_ex, live_mem;
    logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic hazard_ex, hazard_mem, hazard;

    assign live_ex  = ex_wr_en  && (ex_wr_regf  != 5'd0);
    assign live_mem = mem_wr_en && (mem_wr_regf != 5'd0);

    assign rs_ex_hit  = id_use_rs && live_ex  && (ex_wr_regf  == id_rs_regf);
    assign rt_ex_hit  = id_use_rt && live_ex  && (ex_wr_regf  == id_rt_regf);
    assign rs_mem_hit = id_use_rs && live_mem && (mem_wr_regf == id_rs_regf);
    assign rt_mem_hit = id_use_rt && live_mem && (mem_wr_regf == id_rt_regf);

    // EX results are never forwardable to ID: loads always interlock, branches wait for EX to retire
    assign hazard_ex = (rs_ex_hit || rt_ex_hit) && (ex_is_load || id_is_branch);

`ifdef ID_MEM_FWD_EN
    assign forward_rs = rs_mem_hit && !mem_is_load;
    assign forward_rt = rt_mem_hit && !mem_is_load;
    assign hazard_mem = id_is_branch && (rs_mem_hit || rt_mem_hit) && mem_is_load;
`else
    logic unused_mem_is_load;
    assign unused_mem_is_load = mem_is_load;
    assign forward_rs = 1'b0;
    assign forward_rt = 1'b0;
    assign hazard_mem = id_is_branch && (rs_mem_hit || rt_mem_hit);
`endif

    assign hazard = hazard_ex || hazard_mem;

    // Counter holds remaining BUSY cycles minus one; start cycle itself counts as busy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else if (exc_flush) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_div_start) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q == 6'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 6'd0;
                end
            endcase
        end
    end

    assign div_busy = resetn && !exc_flush &&
                      ((state_q == BUSY) || ((state_q == IDLE) && ex_div_start));
    assign div_done = (state_q == DONE);

    // Gated by resetn so the stall/flush lines drop immediately on asynchronous reset
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        stall_ex = 1'b0;
        flush_ex = 1'b0;
        if (!resetn) begin
            flush_ex = 1'b0;
        end else if (exc_flush) begin
            flush_ex = 1'b1;
        end else if (div_busy) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
        end else if (hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

endmodule
